// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg
// Elastic EX->MEM pipeline register. A main register drives the outputs, and a
// skid register absorbs the one extra bundle that can arrive in the cycle MEM
// stalls. This keeps in_ready a function of state only, so back-pressure never
// forms a combinational path from MEM back into EX.
//
// Ports
//   Clk, rst          clock, asynchronous active-high reset
//   flush             synchronous; turns every held entry into a bubble
//   in_valid/in_ready EX-side handshake (in_ready depends on state only)
//   WB_Enable, MemRead, MemWrite, PC, ALU_Result, ST_Value, DstReg
//                     bundle from EX
//   out_valid/out_ready MEM-side handshake
//   WBEnable, MemReadOut, MemWriteOut, PCOut, ALU_ResultOut, ST_ValueOut,
//   DstRegOut         bundle to MEM; the control bits are 0 while out_valid=0
//
// state | meaning
// ------+------------------------------------------
// EMPTY | main empty, skid empty
// ONE   | main holds the head bundle, skid empty
// TWO   | main holds the head, skid holds the next one
module ex_mem_stage_reg #(
   parameter int DATA_W = 16,
   parameter int PC_W   = 10,
   parameter int REG_W  = 4
) (
   input  logic              Clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              WB_Enable,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [PC_W-1:0]   PC,
   input  logic [DATA_W-1:0] ALU_Result,
   input  logic [DATA_W-1:0] ST_Value,
   input  logic [REG_W-1:0]  DstReg,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              WBEnable,
   output logic              MemReadOut,
   output logic              MemWriteOut,
   output logic [PC_W-1:0]   PCOut,
   output logic [DATA_W-1:0] ALU_ResultOut,
   output logic [DATA_W-1:0] ST_ValueOut,
   output logic [REG_W-1:0]  DstRegOut
);

   // Bundle layout, MSB first: {wb, mem_read, mem_write, pc, alu, st, dst}.
   localparam int BW = 3 + PC_W + 2 * DATA_W + REG_W;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   main_q, main_d;
   logic [BW-1:0]   skid_q, skid_d;
   logic [BW-1:0]   in_bundle;
   logic            accept;
   logic            drain;

   assign in_bundle = {WB_Enable, MemRead, MemWrite, PC, ALU_Result, ST_Value, DstReg};

   assign in_ready  = (state_q != ST_TWO);
   assign out_valid = (state_q != ST_EMPTY);
   assign accept    = in_valid & in_ready;
   assign drain     = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         // Data fields are kept; only the control bits have to become bubbles.
         state_d          = ST_EMPTY;
         main_d[BW-1 -: 3] = 3'b000;
         skid_d[BW-1 -: 3] = 3'b000;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  main_d  = in_bundle;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && drain) begin
                  main_d = in_bundle;
               end else if (accept) begin
                  skid_d  = in_bundle;
                  state_d = ST_TWO;
               end else if (drain) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (drain) begin
                  main_d  = skid_q;
                  state_d = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   // Control bits are gated so a bubble can never write memory or the RF.
   assign WBEnable      = main_q[BW-1] & out_valid;
   assign MemReadOut    = main_q[BW-2] & out_valid;
   assign MemWriteOut   = main_q[BW-3] & out_valid;
   assign PCOut         = main_q[BW-4 -: PC_W];
   assign ALU_ResultOut = main_q[2*DATA_W+REG_W-1 -: DATA_W];
   assign ST_ValueOut   = main_q[DATA_W+REG_W-1 -: DATA_W];
   assign DstRegOut     = main_q[REG_W-1:0];

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
module tb_ex_mem_stage_reg;

   logic        Clk;
   logic        rst;
   logic        flush;
   logic        in_valid, in_ready;
   logic        WB_Enable, MemRead, MemWrite;
   logic [9:0]  PC;
   logic [15:0] ALU_Result, ST_Value;
   logic [3:0]  DstReg;
   logic        out_valid, out_ready;
   logic        WBEnable, MemReadOut, MemWriteOut;
   logic [9:0]  PCOut;
   logic [15:0] ALU_ResultOut, ST_ValueOut;
   logic [3:0]  DstRegOut;

   logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
   logic        w_wbo, w_mro, w_mwo;
   logic [31:0] w_pc, w_alu, w_st, w_pco, w_aluo, w_sto;
   logic [4:0]  w_dst, w_dsto;

   int n_vec = 0;
   int n_err = 0;

   ex_mem_stage_reg u_dut (
      .Clk(Clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .WB_Enable(WB_Enable), .MemRead(MemRead), .MemWrite(MemWrite),
      .PC(PC), .ALU_Result(ALU_Result), .ST_Value(ST_Value), .DstReg(DstReg),
      .out_valid(out_valid), .out_ready(out_ready),
      .WBEnable(WBEnable), .MemReadOut(MemReadOut), .MemWriteOut(MemWriteOut),
      .PCOut(PCOut), .ALU_ResultOut(ALU_ResultOut), .ST_ValueOut(ST_ValueOut),
      .DstRegOut(DstRegOut)
   );

   ex_mem_stage_reg #(.DATA_W(32), .PC_W(32), .REG_W(5)) u_wide (
      .Clk(Clk), .rst(rst), .flush(1'b0),
      .in_valid(w_in_valid), .in_ready(w_in_ready),
      .WB_Enable(1'b1), .MemRead(1'b0), .MemWrite(1'b1),
      .PC(w_pc), .ALU_Result(w_alu), .ST_Value(w_st), .DstReg(w_dst),
      .out_valid(w_out_valid), .out_ready(w_out_ready),
      .WBEnable(w_wbo), .MemReadOut(w_mro), .MemWriteOut(w_mwo),
      .PCOut(w_pco), .ALU_ResultOut(w_aluo), .ST_ValueOut(w_sto),
      .DstRegOut(w_dsto)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic wb, input logic mr, input logic mw,
                        input logic [9:0] pc, input logic [15:0] alu,
                        input logic [15:0] st, input logic [3:0] dst);
      in_valid   = v;
      WB_Enable  = wb;
      MemRead    = mr;
      MemWrite   = mw;
      PC         = pc;
      ALU_Result = alu;
      ST_Value   = st;
      DstReg     = dst;
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0, 16'h0, 4'h0);
      w_in_valid = 1'b0; w_out_ready = 1'b0;
      w_pc = '0; w_alu = '0; w_st = '0; w_dst = '0;
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_pcout", {54'd0, PCOut}, 64'd0);
      chk("rst_alu", {48'd0, ALU_ResultOut}, 64'd0);
      #12 rst = 1'b0;

      // streaming: one bundle per cycle, 1-cycle latency
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 10'(i), 16'(i * 3), 16'h0, 4'(i));
         tick();
         chk("stream_valid", {63'd0, out_valid}, 64'd1);
         chk("stream_pc", {54'd0, PCOut}, 64'(i));
         chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
      end
      chk("stream_dst", {60'd0, DstRegOut}, 64'd7);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0, 16'h0, 4'h0);
      tick();
      chk("stream_drained", {63'd0, out_valid}, 64'd0);
      chk("stream_bubble_wb", {63'd0, WBEnable}, 64'd0);

      // back-pressure: 1,2 held, 3 waits at the input
      out_ready = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 10'd1, 16'h0, 16'h0, 4'h0);
      tick();
      chk("bp_pc1", {54'd0, PCOut}, 64'd1);
      chk("bp_ready1", {63'd0, in_ready}, 64'd1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 10'd2, 16'h0, 16'h0, 4'h0);
      tick();
      chk("bp_ready2", {63'd0, in_ready}, 64'd0);
      chk("bp_hold_pc1", {54'd0, PCOut}, 64'd1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 10'd3, 16'h0, 16'h0, 4'h0);
      tick();
      chk("bp_stall_pc1", {54'd0, PCOut}, 64'd1);
      chk("bp_stall_ready", {63'd0, in_ready}, 64'd0);
      out_ready = 1'b1;
      tick();
      chk("bp_pc2", {54'd0, PCOut}, 64'd2);
      chk("bp_ready_back", {63'd0, in_ready}, 64'd1);
      tick();
      chk("bp_pc3", {54'd0, PCOut}, 64'd3);
      chk("bp_valid3", {63'd0, out_valid}, 64'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0, 16'h0, 4'h0);
      tick();
      chk("bp_empty", {63'd0, out_valid}, 64'd0);

      // flush while two entries are held; PC=6 must be discarded
      out_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 10'd4, 16'h0, 16'h0, 4'h0);
      tick();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 10'd5, 16'h0, 16'h0, 4'h0);
      tick();
      chk("fl_two_pc4", {54'd0, PCOut}, 64'd4);
      chk("fl_two_mw", {63'd0, MemWriteOut}, 64'd1);
      chk("fl_two_ready", {63'd0, in_ready}, 64'd0);
      flush = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 10'd6, 16'h0, 16'h0, 4'h0);
      tick();
      flush = 1'b0;
      chk("fl_valid", {63'd0, out_valid}, 64'd0);
      chk("fl_mw", {63'd0, MemWriteOut}, 64'd0);
      chk("fl_mr", {63'd0, MemReadOut}, 64'd0);
      chk("fl_wb", {63'd0, WBEnable}, 64'd0);
      chk("fl_ready", {63'd0, in_ready}, 64'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0, 16'h0, 4'h0);
      out_ready = 1'b1;
      tick();
      chk("fl_still_empty", {63'd0, out_valid}, 64'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 10'd7, 16'h0, 16'h0, 4'h0);
      tick();
      chk("fl_next_pc7", {54'd0, PCOut}, 64'd7);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0, 16'h0, 4'h0);
      tick();
      chk("fl_drained", {63'd0, out_valid}, 64'd0);

      // bubble gating: store drained, data stays, MemWriteOut drops
      drive(1'b1, 1'b0, 1'b0, 1'b1, 10'd8, 16'h0100, 16'hBEEF, 4'h2);
      tick();
      chk("bub_mw_on", {63'd0, MemWriteOut}, 64'd1);
      chk("bub_st_on", {48'd0, ST_ValueOut}, 64'hBEEF);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0, 16'h0, 4'h0);
      tick();
      chk("bub_valid", {63'd0, out_valid}, 64'd0);
      chk("bub_mw_off", {63'd0, MemWriteOut}, 64'd0);
      chk("bub_st_keep", {48'd0, ST_ValueOut}, 64'hBEEF);

      // asynchronous reset in TWO
      out_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 10'd9, 16'h5555, 16'hAAAA, 4'h9);
      tick();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 10'd10, 16'h5555, 16'hAAAA, 4'hA);
      tick();
      chk("rs_two_ready", {63'd0, in_ready}, 64'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0, 16'h0, 4'h0);
      #2 rst = 1'b1;
      #1;
      chk("rs_valid", {63'd0, out_valid}, 64'd0);
      chk("rs_ready", {63'd0, in_ready}, 64'd1);
      chk("rs_ctrl", {61'd0, WBEnable, MemReadOut, MemWriteOut}, 64'd0);
      chk("rs_pc", {54'd0, PCOut}, 64'd0);
      chk("rs_st", {48'd0, ST_ValueOut}, 64'd0);
      chk("rs_alu", {48'd0, ALU_ResultOut}, 64'd0);
      chk("rs_dst", {60'd0, DstRegOut}, 64'd0);
      #2 rst = 1'b0;
      #1;
      chk("rs_ready_rel", {63'd0, in_ready}, 64'd1);
      out_ready = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 10'h005, 16'h1234, 16'h0, 4'h3);
      tick();
      chk("rs_first_valid", {63'd0, out_valid}, 64'd1);
      chk("rs_first_pc", {54'd0, PCOut}, 64'h005);
      chk("rs_first_alu", {48'd0, ALU_ResultOut}, 64'h1234);
      chk("rs_first_dst", {60'd0, DstRegOut}, 64'h3);
      chk("rs_first_wb", {63'd0, WBEnable}, 64'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0, 16'h0, 4'h0);
      tick();

      // wide instance
      w_in_valid = 1'b1; w_out_ready = 1'b1;
      w_pc = 32'hCAFE_0001; w_alu = 32'hDEAD_BEEF; w_st = 32'h0123_4567; w_dst = 5'd31;
      tick();
      chk("wide_valid", {63'd0, w_out_valid}, 64'd1);
      chk("wide_alu", {32'd0, w_aluo}, 64'hDEAD_BEEF);
      chk("wide_dst", {59'd0, w_dsto}, 64'd31);
      chk("wide_pc", {32'd0, w_pco}, 64'hCAFE_0001);
      chk("wide_st", {32'd0, w_sto}, 64'h0123_4567);
      chk("wide_ctrl", {61'd0, w_wbo, w_mro, w_mwo}, 64'b101);
      w_in_valid = 1'b0;
      tick();
      chk("wide_empty_mw", {63'd0, w_mwo}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
